rect_loop_frame_loader: RTL

- Receive side of the rectangle-loop datapath: accepts a beat stream carrying one parameter word followed by a packed binary matrix.
- Assembles the stream into a MATRIX_ROW x MATRIX_COL bit matrix plus a PARAM_W-bit parameter.
- Presents the assembled frame to the rectangle-loop core through a valid/ready output handshake.
- Validates frame length and counts delivered and malformed frames.

---
 rtl/rect_loop_frame_loader.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/rect_loop_frame_loader.sv
// Receive-side frame loader: turns a header beat plus packed body beats into one
// parameter word and a row-major bit matrix, then offers it through valid/ready.
module rect_loop_frame_loader #(
    parameter int MATRIX_ROW = 2,
    parameter int MATRIX_COL = 2,
    parameter int PARAM_W    = 12,
    parameter int BEAT_W     = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [BEAT_W-1:0]                in_data,
    input  logic                             in_valid,
    input  logic                             in_last,
    output logic                             in_ready,
    output logic [PARAM_W-1:0]               param_out,
    output logic [MATRIX_ROW*MATRIX_COL-1:0] m_out,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             err_pulse,
    output logic [7:0]                       err_cnt,
    output logic [15:0]                      frame_cnt
);

    // state | meaning
    // HDR   | waiting for the parameter beat
    // BODY  | collecting matrix beats, beat_idx_q counts them
    // DRAIN | long frame seen, discarding beats up to in_last
    // HOLD  | frame complete, offered to the core until out_ready

    localparam int MW     = MATRIX_ROW * MATRIX_COL;
    localparam int NBEATS = (MW + BEAT_W - 1) / BEAT_W;
    localparam int IDX_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBEATS - 1);

    typedef enum logic [1:0] {
        HDR   = 2'd0,
        BODY  = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   beat_idx_q;
    logic [PARAM_W-1:0] param_q;
    logic [MW-1:0]      m_q;
    logic [MW-1:0]      m_d;
    logic               valid_q;
    logic               err_q;
    logic [7:0]         err_cnt_q;
    logic [15:0]        frame_cnt_q;
    logic               accept;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign in_ready = (state_q != HOLD);
    assign accept   = in_valid && in_ready;

    // Merge the current beat into its slice; bits past MW in the final beat fall away.
    always_comb begin
        m_d = m_q;
        for (int b = 0; b < NBEATS; b++) begin
            if (beat_idx_q == IDX_W'(b)) begin
                for (int k = 0; k < BEAT_W; k++) begin
                    if (b * BEAT_W + k < MW) begin
                        m_d[b * BEAT_W + k] = in_data[k];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= HDR;
            beat_idx_q  <= '0;
            param_q     <= '0;
            m_q         <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
            frame_cnt_q <= '0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                HDR: begin
                    if (accept) begin
                        param_q    <= in_data[PARAM_W-1:0];
                        beat_idx_q <= '0;
                        if (in_last) begin
                            err_q     <= 1'b1;
                            err_cnt_q <= sat_inc(err_cnt_q);
                        end else begin
                            state_q <= BODY;
                        end
                    end
                end
                BODY: begin
                    if (accept) begin
                        m_q <= m_d;
                        if (beat_idx_q == LAST_IDX) begin
                            if (in_last) begin
                                state_q <= HOLD;
                                valid_q <= 1'b1;
                            end else begin
                                err_q     <= 1'b1;
                                err_cnt_q <= sat_inc(err_cnt_q);
                                state_q   <= DRAIN;
                            end
                        end else if (in_last) begin
                            err_q     <= 1'b1;
                            err_cnt_q <= sat_inc(err_cnt_q);
                            state_q   <= HDR;
                        end else begin
                            beat_idx_q <= beat_idx_q + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (accept && in_last) begin
                        state_q <= HDR;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        valid_q     <= 1'b0;
                        frame_cnt_q <= frame_cnt_q + 16'd1;
                        state_q     <= HDR;
                    end
                end
                default: state_q <= HDR;
            endcase
        end
    end

    assign param_out = param_q;
    assign m_out     = m_q;
    assign out_valid = valid_q;
    assign err_pulse = err_q;
    assign err_cnt   = err_cnt_q;
    assign frame_cnt = frame_cnt_q;

endmodule
